electronic_piano2: RTL and testbench
====================================

// Module: electronic_piano2
// PURPOSE
//  Top-level electronic piano: 7 note keys, a 2-bit mode switch and an auto-play input drive a buzzer
//  square wave. The current note is shown on an 8x8 red/green dot matrix, one 7-seg digit pair and an
//  LCD1602. Single clock domain; all divisors are parameters so simulation can scale them down.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency; tone dividers = CLK_HZ/(2*f_note)
//  SCAN_DIV    5_000       clk cycles per dot-matrix row / 7-seg digit scan step
//  LCD_STEP    50_000      clk cycles per LCD command/data slot (E high for the first half)
//  NOTE_TICKS  25_000_000  clk cycles per note in auto-play
// PORTS
//  clk    in   1  system clock, rising edge
//  rst    in   1  synchronous, active-high reset
//  sw     in   2  sw[1]=sound enable, sw[0]=octave (0 middle C4..B4, 1 high C5..B5)
//  btn    in   7  note keys, btn[6]=Do(1) .. btn[0]=Ti(7), active-high level
//  auto   in   1  1 = play built-in melody, buttons ignored
//  freq   out  1  buzzer square wave
//  row    out  8  matrix row select, active-low, one row low at a time
//  col_R  out  8  matrix red columns, active-high
//  col_G  out  8  matrix green columns, active-high
//  seg    out  7  segments {a,b,c,d,e,f,g}=seg[6:0], active-high
//  cat    out  8  digit enables, active-low
//  E      out  1  LCD enable strobe
//  RS     out  1  LCD register select (0 cmd, 1 data)
//  data   out  8  LCD data bus
// BEHAVIOUR
//  Reset: freq=0, row=8'hFF, col_R=col_G=0, seg=0, cat=8'hFF, E=0, RS=0, data=0; counters cleared;
//   auto pointer=0; LCD restarts its init sequence.
//  Note select: auto=0 -> highest set btn bit wins (btn[6] over btn[0]); none pressed -> note 0 (rest).
//   auto=1 -> note = ROM[ptr]. ROM holds 16 entries: 1 1 5 5 6 6 5 0 4 4 3 3 2 2 1 0. ptr advances
//   every NOTE_TICKS cycles and wraps 15->0. Dropping auto keeps ptr; the next auto=1 resumes there.
//  Tone: f = {262,294,330,349,392,440,494} Hz (sw[0]=0) or {523,587,659,698,784,880,988} Hz (sw[0]=1).
//   freq toggles when the divider reaches CLK_HZ/(2f)-1. The divider restarts at 0 on any note or
//   octave change.
//  Sound is on when (sw[1] | auto) and note!=0; otherwise freq=0 and the divider is held at 0.
//  7-seg: digit0 (cat[0]) shows note 1..7, or '-' (seg=7'b0000001) when note=0; digit1 (cat[1]) shows
//   octave 1 or 2. The two digits alternate every SCAN_DIV cycles; cat[7:2]=1 always.
//   Codes: 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
//  Matrix: rows scan 0..7 (row[i]=0), advancing every SCAN_DIV cycles. Column n-1 (note n) shows a bar
//   of height 2+n (rows 7 down to 8-(2+n)). Green when sw[0]=0, red when sw[0]=1. Note 0 -> all
//   columns 0.
//  LCD: init cmds 0x38,0x0C,0x06,0x01. Then a loop: 0x80 followed by "NOTE:" + ASCII('0'+note), and
//   0xC0 followed by "OCT:" + ('1'|'2'). Each byte occupies one LCD_STEP slot: data/RS stable for the
//   whole slot, E=1 for the first half, E=0 for the second half. After the final byte the loop
//   restarts at 0x80. RS=0 for commands, 1 for characters.
//  Input changes mid-note take effect on the next clock. rst mid-operation aborts all activity,
//   including any LCD transfer.
// STRUCTURE
//  Package piano2_pkg: note-divider table function (CLK_HZ, note, octave), 7-seg code table, melody
//   ROM, LCD init/command constants.
//  One sub-module lcd1602_driver (clk, rst, note, oct -> E, RS, data); all else inline in the top.
// TESTING  (CLK_HZ=1000, SCAN_DIV=4, LCD_STEP=8, NOTE_TICKS=64)
//  rst=1 3 cycles -> all outputs at reset values; release -> LCD first byte 0x38, RS=0, E=1 for 4 clks.
//  sw=2'b10, btn=7'b1000000 -> freq square wave, half-period round(1000/524)=2 clks; digit0=0110000.
//  sw=2'b11, btn=7'b0110000 -> note 2 (priority); digit1 shows 2; col_R[1] bar height 4; col_G=0.
//  sw=2'b00, btn=7'b0000001 -> freq stays 0; matrix still shows column 6, height 9 -> clamped to 8 rows.
//  auto=1, sw=2'b00 -> notes 1,1,5,5... each held 64 clks; index 7 -> freq=0 and '-' shown; wraps to 0.
//  rst asserted during an LCD data byte -> E=0, data=0 the next cycle; init restarts at 0x38.

Source files
------------

// File: rtl/piano2_pkg.sv
// Shared tables for the electronic piano: tone dividers, 7-seg codes, melody ROM, LCD constants.
package piano2_pkg;

  typedef enum logic [1:0] {
    LCD_INIT  = 2'd0,
    LCD_LINE1 = 2'd1,
    LCD_LINE2 = 2'd2
  } lcd_state_t;

  localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;
  localparam logic [6:0] SEG_DASH      = 7'b0000001;

  function automatic logic [7:0] lcd_init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Half-period of a note in clocks, rounded to nearest; never below 1 so the
  // terminal count stays non-negative even for rests or very slow clocks.
  function automatic int note_div(input int clk_hz, input int note, input int oct);
    int f;
    int h;
    case (note)
      1:       f = (oct != 0) ? 523 : 262;
      2:       f = (oct != 0) ? 587 : 294;
      3:       f = (oct != 0) ? 659 : 330;
      4:       f = (oct != 0) ? 698 : 349;
      5:       f = (oct != 0) ? 784 : 392;
      6:       f = (oct != 0) ? 880 : 440;
      7:       f = (oct != 0) ? 988 : 494;
      default: f = 0;
    endcase
    if (f == 0) return 1;
    h = (clk_hz + f) / (2 * f);
    return (h < 1) ? 1 : h;
  endfunction

  function automatic logic [6:0] seg_code(input logic [2:0] n);
    case (n)
      3'd1:    return 7'b0110000;
      3'd2:    return 7'b1101101;
      3'd3:    return 7'b1111001;
      3'd4:    return 7'b0110011;
      3'd5:    return 7'b1011011;
      3'd6:    return 7'b1011111;
      3'd7:    return 7'b1110000;
      default: return SEG_DASH;
    endcase
  endfunction

  function automatic logic [2:0] melody(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd14:         return 3'd1;
      4'd2, 4'd3, 4'd6:          return 3'd5;
      4'd4, 4'd5:                return 3'd6;
      4'd8, 4'd9:                return 3'd4;
      4'd10, 4'd11:              return 3'd3;
      4'd12, 4'd13:              return 3'd2;
      default:                   return 3'd0;
    endcase
  endfunction

  // Column bits lit in row r for note n: column n-1 holds a bar of height 2+n
  // growing up from row 7; heights above 8 simply fill the column.
  function automatic logic [7:0] bar_cols(input logic [2:0] n, input logic [2:0] r);
    if (n == 3'd0) return 8'h00;
    if (int'(r) + int'(n) >= 6) return 8'b1 << (n - 3'd1);
    return 8'h00;
  endfunction

endpackage

// File: rtl/lcd1602_driver.sv
// LCD1602 write sequencer: init commands, then an endless refresh of "NOTE:n" / "OCT:o".
//  state     | meaning
//  LCD_INIT  | sending the four power-up commands
//  LCD_LINE1 | sending 0x80 then "NOTE:" and the note digit
//  LCD_LINE2 | sending 0xC0 then "OCT:" and the octave digit, then back to LCD_LINE1
module lcd1602_driver
  import piano2_pkg::*;
#(
  parameter int LCD_STEP = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] note,
  input  logic       oct,
  output logic       E,
  output logic       RS,
  output logic [7:0] data
);
  localparam int SLW = $clog2(LCD_STEP + 1);

  lcd_state_t     state;
  logic [2:0]     pos;
  logic [SLW-1:0] slot_cnt;
  logic [7:0]     byte_nxt;
  logic           rs_nxt;

  // Byte and register select for the current sequence position.
  always_comb begin
    byte_nxt = 8'h00;
    rs_nxt   = 1'b1;
    case (state)
      LCD_INIT: begin
        rs_nxt   = 1'b0;
        byte_nxt = lcd_init_cmd(pos[1:0]);
      end
      LCD_LINE1: begin
        case (pos)
          3'd0: begin rs_nxt = 1'b0; byte_nxt = LCD_CMD_LINE1; end
          3'd1: byte_nxt = "N";
          3'd2: byte_nxt = "O";
          3'd3: byte_nxt = "T";
          3'd4: byte_nxt = "E";
          3'd5: byte_nxt = ":";
          default: byte_nxt = 8'h30 + {5'd0, note};
        endcase
      end
      LCD_LINE2: begin
        case (pos)
          3'd0: begin rs_nxt = 1'b0; byte_nxt = LCD_CMD_LINE2; end
          3'd1: byte_nxt = "O";
          3'd2: byte_nxt = "C";
          3'd3: byte_nxt = "T";
          3'd4: byte_nxt = ":";
          default: byte_nxt = oct ? "2" : "1";
        endcase
      end
      default: begin
        rs_nxt   = 1'b0;
        byte_nxt = 8'h00;
      end
    endcase
  end

  // Slot timer and sequence FSM; the byte is latched once per slot so data/RS stay stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LCD_INIT;
      pos      <= 3'd0;
      slot_cnt <= SLW'(LCD_STEP - 1);
      E        <= 1'b0;
      RS       <= 1'b0;
      data     <= 8'h00;
    end else begin
      E <= (slot_cnt >= SLW'(LCD_STEP - LCD_STEP / 2));
      if (slot_cnt == SLW'(LCD_STEP - 1)) begin
        data <= byte_nxt;
        RS   <= rs_nxt;
      end
      if (slot_cnt == '0) begin
        slot_cnt <= SLW'(LCD_STEP - 1);
        case (state)
          LCD_INIT:  if (pos == 3'd3) begin state <= LCD_LINE1; pos <= 3'd0; end
                     else pos <= pos + 3'd1;
          LCD_LINE1: if (pos == 3'd6) begin state <= LCD_LINE2; pos <= 3'd0; end
                     else pos <= pos + 3'd1;
          LCD_LINE2: if (pos == 3'd5) begin state <= LCD_LINE1; pos <= 3'd0; end
                     else pos <= pos + 3'd1;
          default:   begin state <= LCD_INIT; pos <= 3'd0; end
        endcase
      end else begin
        slot_cnt <= slot_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/electronic_piano2.sv
// Electronic piano top: note selection, tone generator, auto-play, matrix/7-seg scan, LCD.
module electronic_piano2
  import piano2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SCAN_DIV   = 5_000,
  parameter int LCD_STEP   = 50_000,
  parameter int NOTE_TICKS = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw,
  input  logic [6:0] btn,
  input  logic       auto,
  output logic       freq,
  output logic [7:0] row,
  output logic [7:0] col_R,
  output logic [7:0] col_G,
  output logic [6:0] seg,
  output logic [7:0] cat,
  output logic       E,
  output logic       RS,
  output logic [7:0] data
);
  localparam int DW  = $clog2(CLK_HZ + 1);
  localparam int SCW = $clog2(SCAN_DIV + 1);
  localparam int NW  = $clog2(NOTE_TICKS + 1);

  logic [2:0]     note, note_q;
  logic           oct_q;
  logic [3:0]     ptr;
  logic [NW-1:0]  note_cnt;
  logic [SCW-1:0] scan_cnt;
  logic [2:0]     scan_idx;
  logic [DW-1:0]  tone_cnt;
  logic [DW-1:0]  tone_tc_tbl [16];
  logic           sound_on;
  logic [7:0]     bar;

  // Terminal counts indexed by {octave, note}; built at elaboration from constants.
  for (genvar g = 0; g < 16; g++) begin : g_tone
    localparam int TC = note_div(CLK_HZ, g % 8, g / 8) - 1;
    assign tone_tc_tbl[g] = DW'(TC);
  end

  // Note select: melody ROM in auto-play, otherwise the highest pressed key.
  always_comb begin
    note = 3'd0;
    if (auto) begin
      note = melody(ptr);
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (btn[i]) note = 3'(7 - i);
      end
    end
  end

  assign sound_on = (sw[1] | auto) && (note != 3'd0);
  assign bar      = bar_cols(note, scan_idx);

  // Tone divider: restarts on any note/octave change, silent and cleared when sound is off.
  always_ff @(posedge clk) begin
    if (rst) begin
      freq     <= 1'b0;
      tone_cnt <= '0;
      note_q   <= 3'd0;
      oct_q    <= 1'b0;
    end else begin
      note_q <= note;
      oct_q  <= sw[0];
      if (!sound_on) begin
        freq     <= 1'b0;
        tone_cnt <= '0;
      end else if (note != note_q || sw[0] != oct_q) begin
        tone_cnt <= '0;
      end else if (tone_cnt == tone_tc_tbl[{sw[0], note}]) begin
        tone_cnt <= '0;
        freq     <= ~freq;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end
    end
  end

  // Auto-play pointer: advances every NOTE_TICKS while auto is high, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= 4'd0;
      note_cnt <= NW'(NOTE_TICKS - 1);
    end else if (!auto) begin
      note_cnt <= NW'(NOTE_TICKS - 1);
    end else if (note_cnt == '0) begin
      note_cnt <= NW'(NOTE_TICKS - 1);
      ptr      <= ptr + 4'd1;
    end else begin
      note_cnt <= note_cnt - 1'b1;
    end
  end

  // Shared scan timer for matrix rows and 7-seg digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= SCW'(SCAN_DIV - 1);
      scan_idx <= 3'd0;
    end else if (scan_cnt == '0) begin
      scan_cnt <= SCW'(SCAN_DIV - 1);
      scan_idx <= scan_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt - 1'b1;
    end
  end

  // Registered display drive: matrix row/columns and the two-digit 7-seg.
  always_ff @(posedge clk) begin
    if (rst) begin
      row   <= 8'hFF;
      col_R <= 8'h00;
      col_G <= 8'h00;
      seg   <= 7'd0;
      cat   <= 8'hFF;
    end else begin
      row   <= ~(8'b1 << scan_idx);
      col_R <= sw[0] ? bar : 8'h00;
      col_G <= sw[0] ? 8'h00 : bar;
      if (!scan_idx[0]) begin
        cat <= 8'hFE;
        seg <= seg_code(note);
      end else begin
        cat <= 8'hFD;
        seg <= seg_code(sw[0] ? 3'd2 : 3'd1);
      end
    end
  end

  lcd1602_driver #(
    .LCD_STEP(LCD_STEP)
  ) u_lcd (
    .clk (clk),
    .rst (rst),
    .note(note_q),
    .oct (oct_q),
    .E   (E),
    .RS  (RS),
    .data(data)
  );

endmodule

// File: tb/tb_electronic_piano2.sv
// Directed bench for electronic_piano2 with scaled-down divisors.
module tb_electronic_piano2;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sw;
  logic [6:0] btn;
  logic       auto;
  logic       freq, E, RS;
  logic [7:0] row, col_R, col_G, cat, data;
  logic [6:0] seg;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  electronic_piano2 #(
    .CLK_HZ(1000), .SCAN_DIV(4), .LCD_STEP(8), .NOTE_TICKS(64)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn), .auto(auto),
    .freq(freq), .row(row), .col_R(col_R), .col_G(col_G),
    .seg(seg), .cat(cat), .E(E), .RS(RS), .data(data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Seg value while the requested digit is enabled; 32'hDEAD_BEEF on timeout.
  task automatic read_digit(input logic [7:0] want, output logic [31:0] s);
    bit seen = 0;
    s = 32'hDEAD_BEEF;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (cat == want) begin s = {25'd0, seg}; seen = 1; end
    end
  endtask

  // {col_R, col_G} while matrix row r is selected.
  task automatic read_row(input int r, output logic [31:0] rg);
    bit seen = 0;
    logic [7:0] sel;
    sel = ~(8'b1 << r);
    rg = 32'hDEAD_BEEF;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (row == sel) begin rg = {16'd0, col_R, col_G}; seen = 1; end
    end
  endtask

  // Clocks between two consecutive freq edges; -1 on timeout.
  task automatic half_period(output int h);
    bit seen = 0;
    logic prev;
    h = -1;
    prev = freq;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (freq !== prev) seen = 1;
    end
    if (seen) begin
      seen = 0;
      prev = freq;
      for (int i = 1; i <= 50 && !seen; i++) begin
        @(negedge clk);
        if (freq !== prev) begin seen = 1; h = i; end
      end
    end
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (freq !== 1'b0) hi++;
    end
  endtask

  task automatic wait_lcd(input logic [7:0] want, output bit ok);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (E && data == want) ok = 1;
    end
  endtask

  task automatic wait_cyc(input int t);
    for (int i = 0; i < 5000 && cyc < t; i++) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int h, hi, start;
    bit ok;
    int         k_list [8] = '{0, 2, 4, 7, 8, 10, 15, 16};
    logic [6:0] k_seg  [8] = '{7'b0110000, 7'b1011011, 7'b1011111, 7'b0000001,
                               7'b0110011, 7'b1111001, 7'b0000001, 7'b0110000};

    rst = 1'b1; sw = 2'b00; btn = 7'd0; auto = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_freq", freq, 0);
    check("rst_row", row, 8'hFF);
    check("rst_col_R", col_R, 0);
    check("rst_col_G", col_G, 0);
    check("rst_seg", seg, 0);
    check("rst_cat", cat, 8'hFF);
    check("rst_E", E, 0);
    check("rst_RS", RS, 0);
    check("rst_data", data, 0);

    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lcd_e_high", E, 1);
    end
    check("lcd_first", data, 8'h38);
    check("lcd_first_rs", RS, 0);
    @(negedge clk);
    check("lcd_e_low", E, 0);
    check("lcd_hold", data, 8'h38);
    repeat (4) @(negedge clk);
    check("lcd_second", data, 8'h0C);
    check("lcd_second_e", E, 1);

    // Do, low octave, sound on
    sw = 2'b10; btn = 7'b1000000;
    repeat (3) @(negedge clk);
    half_period(h);
    check("do_half", h, 2);
    read_digit(8'hFE, v); check("do_digit0", v, 7'b0110000);
    read_digit(8'hFD, v); check("do_digit1", v, 7'b0110000);
    read_row(7, v); check("do_row7", v, {8'h00, 8'h01});
    read_row(5, v); check("do_row5", v, {8'h00, 8'h01});
    read_row(4, v); check("do_row4", v, {8'h00, 8'h00});

    // Two keys: Re wins, high octave, red
    sw = 2'b11; btn = 7'b0110000;
    repeat (3) @(negedge clk);
    half_period(h);
    check("re_half", h, 1);
    read_digit(8'hFE, v); check("re_digit0", v, 7'b1101101);
    read_digit(8'hFD, v); check("re_digit1", v, 7'b1101101);
    read_row(4, v); check("re_row4", v, {8'h02, 8'h00});
    read_row(3, v); check("re_row3", v, {8'h00, 8'h00});
    read_row(7, v); check("re_row7", v, {8'h02, 8'h00});

    // Ti with sound disabled: silent, full-height column
    sw = 2'b00; btn = 7'b0000001;
    repeat (2) @(negedge clk);
    count_high(30, hi);
    check("ti_silent", hi, 0);
    read_row(0, v); check("ti_row0", v, {8'h00, 8'h40});
    read_row(7, v); check("ti_row7", v, {8'h00, 8'h40});
    read_digit(8'hFE, v); check("ti_digit0", v, 7'b1110000);
    read_digit(8'hFD, v); check("ti_digit1", v, 7'b0110000);

    wait_lcd(8'h80, ok);
    check("lcd_line1_cmd", ok, 1);
    repeat (8) @(negedge clk);
    check("lcd_char_N", data, 8'h4E);
    check("lcd_char_rs", RS, 1);
    repeat (40) @(negedge clk);
    check("lcd_note_char", data, 8'h37);
    repeat (8) @(negedge clk);
    check("lcd_line2_cmd", data, 8'hC0);
    check("lcd_line2_rs", RS, 0);
    repeat (40) @(negedge clk);
    check("lcd_oct_char", data, 8'h31);

    // Auto-play with a key held (ignored) and sound switch off
    btn = 7'b1000000; auto = 1'b1;
    start = cyc;
    for (int j = 0; j < 8; j++) begin
      wait_cyc(start + 64 * k_list[j] + 30);
      read_digit(8'hFE, v);
      check($sformatf("auto_digit_k%0d", k_list[j]), v, k_seg[j]);
      if (k_list[j] == 2) begin
        half_period(h);
        check("auto_sol_half", h, 1);
      end
      if (k_list[j] == 7) begin
        count_high(10, hi);
        check("auto_rest_silent", hi, 0);
      end
    end

    // Reset during an LCD character byte
    auto = 1'b0; btn = 7'd0;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (RS && E) ok = 1;
    end
    check("lcd_char_found", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_E", E, 0);
    check("abort_data", data, 0);
    check("abort_RS", RS, 0);
    check("abort_row", row, 8'hFF);
    rst = 1'b0;
    @(negedge clk);
    check("restart_data", data, 8'h38);
    check("restart_E", E, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
